// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the 7-segment scan driver.
//   - Active-low segment patterns, bit7 = dp, bits6..0 = g..a.
//     Every pattern has bit7 set, so the dp stays dark unless it is cleared.
//   - FSM state encoding for the scanner.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hc0;
    localparam logic [7:0] SEG_1     = 8'hf9;
    localparam logic [7:0] SEG_2     = 8'ha4;
    localparam logic [7:0] SEG_3     = 8'hb0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hf8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hff;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        GAP = 2'd1,
        ON  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational BCD nibble to active-low 7-segment pattern.
//   nibble  in  4  BCD value; A..F decode to all segments off
//   dp      in  1  1 lights the decimal point (clears bit7)
//   blank   in  1  1 forces segments g..a off; dp still follows the dp input
//   seg     out 8  active-low segments, bit7 = dp, bits6..0 = g..a
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] base;

    always_comb begin
        case (nibble)
            4'd0:    base = SEG_0;
            4'd1:    base = SEG_1;
            4'd2:    base = SEG_2;
            4'd3:    base = SEG_3;
            4'd4:    base = SEG_4;
            4'd5:    base = SEG_5;
            4'd6:    base = SEG_6;
            4'd7:    base = SEG_7;
            4'd8:    base = SEG_8;
            4'd9:    base = SEG_9;
            default: base = SEG_BLANK;
        endcase
    end

    always_comb begin
        seg = base;
        if (blank) begin
            seg[6:0] = 7'h7f;
        end
        seg[7] = ~dp;
    end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed driver for an NDIG-digit common-anode display.
//   clk        in  1       system clock, rising edge
//   rst_syn    in  1       synchronous active-high reset
//   en         in  1       scan enable; 0 blanks and parks the scanner at slot 0
//   digits     in  4*NDIG  packed BCD, nibble i = digit i (digit 0 rightmost)
//   dp_mask    in  NDIG    bit i lights the decimal point of digit i
//   seg_out    out 8       registered active-low segments (bit7 = dp)
//   dig_sel    out NDIG    registered active-low digit enables
//   scan_tick  out 1       one-cycle pulse on the last cycle of each frame
// Optional build macro: LEAD_ZERO_BLANK_EN suppresses leading zeros on
// digits above digit 0.
module seg_scan
    import seg_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 1000,
    parameter int GAP_CYC  = 2
) (
    input  logic                clk,
    input  logic                rst_syn,
    input  logic                en,
    input  logic [4*NDIG-1:0]   digits,
    input  logic [NDIG-1:0]     dp_mask,
    output logic [7:0]          seg_out,
    output logic [NDIG-1:0]     dig_sel,
    output logic                scan_tick
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(NDIG);
    localparam logic [PW-1:0] PMAX  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] GAP_L = PW'(GAP_CYC);
    localparam logic [IW-1:0] IMAX  = IW'(NDIG - 1);

    scan_state_t           state;
    logic [PW-1:0]         pcnt, pcnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic                  last_p, frame_start;
    logic [4*NDIG-1:0]     snap_dig;
    logic [NDIG-1:0]       snap_dp;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_blank;
    logic [7:0]            dec_seg;
    logic [NDIG-1:0]       sel_on;

    // Next counter values; leaving OFF always starts slot 0 at pcnt 0, which
    // is also the cycle the snapshot is taken.
    always_comb begin
        last_p = (pcnt == PMAX);
        if (state == OFF) begin
            pcnt_nxt    = '0;
            idx_nxt     = '0;
            frame_start = 1'b1;
        end else begin
            pcnt_nxt    = last_p ? '0 : pcnt + PW'(1);
            idx_nxt     = last_p ? ((idx == IMAX) ? '0 : idx + IW'(1)) : idx;
            frame_start = last_p && (idx == IMAX);
        end
    end

    assign cur_nib = snap_dig[{idx, 2'b00} +: 4];
    assign cur_dp  = snap_dp[idx];

`ifdef LEAD_ZERO_BLANK_EN
    logic [NDIG-1:0] lz;
    logic            acc;

    // lz[i]: digit i and every more-significant digit are zero; digit 0 exempt.
    always_comb begin
        lz  = '0;
        acc = 1'b1;
        for (int unsigned i = NDIG - 1; i > 0; i--) begin
            acc   = acc & (snap_dig[4*i +: 4] == 4'h0);
            lz[i] = acc;
        end
    end

    assign cur_blank = lz[idx];
`else
    assign cur_blank = 1'b0;
`endif

    seg_decode u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .blank  (cur_blank),
        .seg    (dec_seg)
    );

    always_comb begin
        sel_on      = '1;
        sel_on[idx] = 1'b0;
    end

    // Outputs are registered from the current counters (one cycle behind),
    // but reset and en=0 blank them on the very next edge.
    always_ff @(posedge clk) begin
        if (rst_syn) begin
            state     <= OFF;
            pcnt      <= '0;
            idx       <= '0;
            snap_dig  <= '0;
            snap_dp   <= '0;
            seg_out   <= SEG_BLANK;
            dig_sel   <= '1;
            scan_tick <= 1'b0;
        end else if (!en) begin
            state     <= OFF;
            pcnt      <= '0;
            idx       <= '0;
            seg_out   <= SEG_BLANK;
            dig_sel   <= '1;
            scan_tick <= 1'b0;
        end else begin
            pcnt <= pcnt_nxt;
            idx  <= idx_nxt;
            case (state)
                OFF:     state <= (GAP_CYC == 0) ? ON : GAP;
                GAP:     state <= (pcnt_nxt >= GAP_L) ? ON : GAP;
                ON:      state <= (last_p && GAP_CYC != 0) ? GAP : ON;
                default: state <= OFF;
            endcase
            if (frame_start) begin
                snap_dig <= digits;
                snap_dp  <= dp_mask;
            end
            if (state == ON) begin
                seg_out <= dec_seg;
                dig_sel <= sel_on;
            end else begin
                seg_out <= SEG_BLANK;
                dig_sel <= '1;
            end
            scan_tick <= (state != OFF) && last_p && (idx == IMAX);
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst_syn;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        scan_tick;

    int checks = 0;
    int errors = 0;

    seg_scan #(.NDIG(4), .PRESCALE(8), .GAP_CYC(2)) dut (
        .clk       (clk),
        .rst_syn   (rst_syn),
        .en        (en),
        .digits    (digits),
        .dp_mask   (dp_mask),
        .seg_out   (seg_out),
        .dig_sel   (dig_sel),
        .scan_tick (scan_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     dig;
        logic [3:0]      dp;
        logic [3:0][7:0] exp;   // exp[s] = seg_out expected in slot s
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_blank(input string name);
        chk({name, ".seg"},  32'(seg_out),   32'hff);
        chk({name, ".sel"},  32'(dig_sel),   32'hf);
        chk({name, ".tick"}, 32'(scan_tick), 32'h0);
    endtask

    // Output after edge k (k counted from the edge that first samples en=1)
    // reflects internal cycle j = k-1: slot (j/8)%4, pcnt j%8.
    task automatic check_window(input string name, input logic [3:0][7:0] exp,
                                input int k0, input int k1);
        int j;
        int slot;
        logic [7:0] eseg;
        logic [3:0] esel;
        logic       etick;
        for (int k = k0; k <= k1; k++) begin
            @(posedge clk);
            @(negedge clk);
            j     = k - 1;
            eseg  = 8'hff;
            esel  = 4'hf;
            etick = 1'b0;
            if (j >= 0 && (j % 8) >= 2) begin
                slot       = (j / 8) % 4;
                eseg       = exp[slot];
                esel[slot] = 1'b0;
            end
            if (j >= 0 && (j % 32) == 31) etick = 1'b1;
            chk({name, ".seg"},  32'(seg_out),   32'(eseg));
            chk({name, ".sel"},  32'(dig_sel),   32'(esel));
            chk({name, ".tick"}, 32'(scan_tick), 32'(etick));
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_syn = 1'b1;
        en      = 1'b1;
        digits  = 16'h0;
        dp_mask = 4'h0;

        vecs[0] = '{16'h1234, 4'b0000, {8'hf9, 8'ha4, 8'hb0, 8'h99}};
        vecs[1] = '{16'h12A4, 4'b0100, {8'hf9, 8'h24, 8'hff, 8'h99}};
`ifdef LEAD_ZERO_BLANK_EN
        vecs[2] = '{16'h0070, 4'b0000, {8'hff, 8'hff, 8'hf8, 8'hc0}};
        vecs[4] = '{16'h0000, 4'b1000, {8'h7f, 8'hff, 8'hff, 8'hc0}};
`else
        vecs[2] = '{16'h0070, 4'b0000, {8'hc0, 8'hc0, 8'hf8, 8'hc0}};
        vecs[4] = '{16'h0000, 4'b1000, {8'h40, 8'hc0, 8'hc0, 8'hc0}};
`endif
        vecs[3] = '{16'h9805, 4'b1001, {8'h10, 8'h80, 8'hc0, 8'h12}};
        vecs[5] = '{16'hFEDB, 4'b0000, {8'hff, 8'hff, 8'hff, 8'hff}};

        // Reset held with en=1: outputs stay blank.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk_blank("reset");
        end

        // Table: one full frame per vector starting from OFF.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            rst_syn = 1'b0;
            en      = 1'b0;
            @(negedge clk);
            digits  = vecs[v].dig;
            dp_mask = vecs[v].dp;
            en      = 1'b1;
            check_window($sformatf("vec%0d", v), vecs[v].exp, 0, 33);
        end

        // Snapshot: change inputs during slot 1; new value appears next frame.
        go_idle();
        digits  = 16'h1234;
        dp_mask = 4'h0;
        en      = 1'b1;
        check_window("snap_a", vecs[0].exp, 0, 12);
        digits = 16'h5678;
        check_window("snap_b", vecs[0].exp, 13, 32);
        check_window("snap_c", {8'h92, 8'h82, 8'hf8, 8'h80}, 33, 66);

        // Abort: drop en at slot 2 pcnt 5, then restart with a fresh snapshot.
        go_idle();
        digits = 16'h1234;
        en     = 1'b1;
        check_window("abort_pre", vecs[0].exp, 0, 21);
        chk("abort_pre.seg", 32'(seg_out), 32'ha4);
        en     = 1'b0;
        digits = 16'h5678;
        @(posedge clk);
        @(negedge clk);
        chk_blank("abort_off0");
        @(posedge clk);
        @(negedge clk);
        chk_blank("abort_off1");
        en = 1'b1;
        check_window("abort_re", {8'h92, 8'h82, 8'hf8, 8'h80}, 0, 33);

        // Synchronous reset mid-frame, then resume from slot 0.
        check_window("rst_pre", {8'h92, 8'h82, 8'hf8, 8'h80}, 34, 44);
        rst_syn = 1'b1;
        digits  = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        chk_blank("rst_mid");
        rst_syn = 1'b0;
        check_window("rst_post", vecs[0].exp, 0, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
